// File: rtl/vend_dispenser_if.sv
// Request and actuator signal bundle between the vending FSM and the dispenser.
// The master side issues vend requests; the slave side drives the actuators and status.
interface vend_dispenser_if;
  logic       release_soda;
  logic [2:0] change;
  logic       vend_motor;
  logic       nickel_eject;
  logic       busy;
  logic       pending;
  logic       overflow;
  logic       bad_change;
  logic [7:0] nickels_paid;

  modport master (
    output release_soda, change,
    input  vend_motor, nickel_eject, busy, pending, overflow, bad_change, nickels_paid
  );

  modport slave (
    input  release_soda, change,
    output vend_motor, nickel_eject, busy, pending, overflow, bad_change, nickels_paid
  );
endinterface

// File: rtl/vend_dispenser.sv
// Soda dispenser actuator sequencer: one timed motor pulse, then one timed ejector
// pulse per nickel of change, with a single-entry buffer for an overlapping request.
module vend_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MAX_NICKELS  = 4
) (
  input logic             clock,
  input logic             reset,
  vend_dispenser_if.slave bus
);

  localparam int unsigned TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned NW   = (MAX_NICKELS > 0) ? $clog2(MAX_NICKELS + 1) : 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, VEND_ON, VEND_GAP, EJECT_ON, EJECT_GAP} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [NW-1:0]  rem_q, rem_d;
  logic           pend_v_q, pend_v_d;
  logic [NW-1:0]  pend_n_q, pend_n_d;
  logic           ovf_q, ovf_d;
  logic           bad_q, bad_d;
  logic [7:0]     paid_q, paid_d;

  logic           req;
  logic           too_big;
  logic [NW-1:0]  n_in;
  logic           expired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      rem_q    <= '0;
      pend_v_q <= 1'b0;
      pend_n_q <= '0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      paid_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rem_q    <= rem_d;
      pend_v_q <= pend_v_d;
      pend_n_q <= pend_n_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      paid_q   <= paid_d;
    end
  end

  always_comb begin
    logic          do_start;
    logic          finish;
    logic [NW-1:0] start_n;

    req      = bus.release_soda;
    too_big  = 32'(bus.change) > MAX_NICKELS;
    n_in     = too_big ? NW'(MAX_NICKELS) : NW'(bus.change);
    expired  = (timer_q == '0);

    state_d  = state_q;
    timer_d  = expired ? timer_q : timer_q - TW'(1);
    rem_d    = rem_q;
    pend_v_d = pend_v_q;
    pend_n_d = pend_n_q;
    ovf_d    = ovf_q;
    bad_d    = bad_q | (req & too_big);
    paid_d   = paid_q;
    do_start = 1'b0;
    finish   = 1'b0;
    start_n  = '0;

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          do_start = 1'b1;
          start_n  = pend_n_q;
          pend_v_d = req;
          if (req) pend_n_d = n_in;
        end else if (req) begin
          do_start = 1'b1;
          start_n  = n_in;
        end
      end
      VEND_ON: begin
        if (expired) begin
          state_d = VEND_GAP;
          timer_d = GAP_LD;
        end
      end
      VEND_GAP, EJECT_GAP: begin
        if (expired) begin
          if (rem_q != '0) begin
            state_d = EJECT_ON;
            timer_d = PULSE_LD;
          end else begin
            finish = 1'b1;
          end
        end
      end
      EJECT_ON: begin
        if (expired) begin
          state_d = EJECT_GAP;
          timer_d = GAP_LD;
          rem_d   = rem_q - NW'(1);
          paid_d  = paid_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      if (pend_v_q) begin
        do_start = 1'b1;
        start_n  = pend_n_q;
        pend_v_d = 1'b0;
      end
    end

    // Busy-side capture is judged on the buffer as it was before this edge, so a
    // request on a finish edge that drains the buffer is still dropped.
    if (req && state_q != IDLE) begin
      if (!pend_v_q) begin
        pend_v_d = 1'b1;
        pend_n_d = n_in;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (do_start) begin
      state_d = VEND_ON;
      timer_d = PULSE_LD;
      rem_d   = start_n;
    end
  end

  always_comb begin
    bus.vend_motor   = (state_q == VEND_ON);
    bus.nickel_eject = (state_q == EJECT_ON);
    bus.busy         = (state_q != IDLE);
    bus.pending      = pend_v_q;
    bus.overflow     = ovf_q;
    bus.bad_change   = bad_q;
    bus.nickels_paid = paid_q;
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: directed scenarios then random requests, every cycle
// compared against a job-timeline reference model.
module tb_vend_dispenser;

  localparam int P = 4;
  localparam int G = 2;
  localparam int M = 4;

  logic clock;
  logic reset;
  vend_dispenser_if bus();

  vend_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .MAX_NICKELS (M)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a running job is just (length, elapsed cycles); outputs are
  // derived arithmetically from the elapsed count.
  bit m_active;
  int m_len;
  int m_k;
  bit m_pv;
  int m_pn;
  bit m_ovf;
  bit m_bad;
  int m_paid;

  function automatic bit exp_motor();
    return m_active && (m_k < P);
  endfunction

  function automatic bit exp_eject();
    return m_active && (m_k >= P + G) && (((m_k - (P + G)) % (P + G)) < P);
  endfunction

  task automatic model_reset();
    m_active = 0; m_len = 0; m_k = 0;
    m_pv = 0; m_pn = 0; m_ovf = 0; m_bad = 0; m_paid = 0;
  endtask

  task automatic model_start(input int n);
    m_active = 1;
    m_len    = (P + G) * (1 + n);
    m_k      = 0;
  endtask

  task automatic model_edge(input bit r, input logic [2:0] c);
    int n;
    bit pend_before;
    n = (int'(c) > M) ? M : int'(c);
    if (r && int'(c) > M) m_bad = 1;
    pend_before = m_pv;
    if (!m_active) begin
      if (m_pv) begin
        model_start(m_pn);
        m_pv = 0;
        if (r) begin m_pv = 1; m_pn = n; end
      end else if (r) begin
        model_start(n);
      end
    end else begin
      m_k++;
      if (m_k >= P + G && ((m_k - (P + G)) % (P + G)) == P) m_paid = (m_paid + 1) % 256;
      if (m_k == m_len) begin
        m_active = 0;
        if (m_pv) begin
          model_start(m_pn);
          m_pv = 0;
        end
      end
      if (r) begin
        if (!pend_before) begin m_pv = 1; m_pn = n; end
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vend_motor"},   8'(bus.vend_motor),   8'(exp_motor()));
    check({tag, ".nickel_eject"}, 8'(bus.nickel_eject), 8'(exp_eject()));
    check({tag, ".busy"},         8'(bus.busy),         8'(m_active));
    check({tag, ".pending"},      8'(bus.pending),      8'(m_pv));
    check({tag, ".overflow"},     8'(bus.overflow),     8'(m_ovf));
    check({tag, ".bad_change"},   8'(bus.bad_change),   8'(m_bad));
    check({tag, ".nickels_paid"}, bus.nickels_paid,     8'(m_paid));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input bit r, input logic [2:0] c);
    bus.release_soda = r;
    bus.change       = c;
    @(posedge clock);
    model_edge(r, c);
    @(negedge clock);
    bus.release_soda = 1'b0;
    bus.change       = 3'($urandom_range(0, 7));
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 3'($urandom_range(0, 7)));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("in_reset");
    reset = 1'b1;
  endtask

  initial begin
    bus.release_soda = 1'b0;
    bus.change       = 3'd0;
    reset            = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();
    check_all("reset_state");

    // change=2: motor cycles 1-4, ejects 7-10 and 13-16, busy ends after cycle 18
    step("c2", 1'b1, 3'd2);
    idle("c2", 17);
    check("c2_busy_last", 8'(bus.busy), 8'd1);
    idle("c2", 1);
    check("c2_busy_fall", 8'(bus.busy), 8'd0);
    check("c2_paid", bus.nickels_paid, 8'd2);
    idle("c2", 3);

    // change=0: single vend pulse, six busy cycles
    step("c0", 1'b1, 3'd0);
    idle("c0", 8);
    check("c0_paid", bus.nickels_paid, 8'd2);

    // A (1 nickel) then B (3 nickels) while A runs
    step("ab", 1'b1, 3'd1);
    idle("ab", 4);
    step("ab", 1'b1, 3'd3);
    check("ab_pending", 8'(bus.pending), 8'd1);
    idle("ab", 40);
    check("ab_paid", bus.nickels_paid, 8'd6);

    // A busy, B pending, C dropped
    step("ovf", 1'b1, 3'd1);
    idle("ovf", 2);
    step("ovf", 1'b1, 3'd2);
    idle("ovf", 2);
    step("ovf", 1'b1, 3'd4);
    check("ovf_set", 8'(bus.overflow), 8'd1);
    idle("ovf", 40);
    check("ovf_paid", bus.nickels_paid, 8'd9);
    check("ovf_sticky", 8'(bus.overflow), 8'd1);

    // Oversized change code clamps to four nickels
    step("bad", 1'b1, 3'd7);
    check("bad_set", 8'(bus.bad_change), 8'd1);
    idle("bad", 32);
    check("bad_paid", bus.nickels_paid, 8'd13);

    // Random requests, long enough for nickels_paid to wrap
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) step("rnd", 1'b1, 3'($urandom_range(0, 7)));
      else step("rnd", 1'b0, 3'($urandom_range(0, 7)));
    end
    idle("drain", 70);

    // Asynchronous reset while the ejector is firing with a request pending
    do_reset();
    step("mid", 1'b1, 3'd2);
    idle("mid", 2);
    step("mid", 1'b1, 3'd1);
    for (int i = 0; i < 40 && !exp_eject(); i++) idle("mid_wait", 1);
    check("mid_eject_reached", 8'(bus.nickel_eject), 8'd1);
    check("mid_pending", 8'(bus.pending), 8'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_eject", 8'(bus.nickel_eject), 8'd0);
    check("async_busy", 8'(bus.busy), 8'd0);
    check("async_pending", 8'(bus.pending), 8'd0);
    check("async_paid", bus.nickels_paid, 8'd0);
    @(negedge clock);
    @(negedge clock);
    check_all("held_reset");
    reset = 1'b1;
    idle("post_reset", 6);
    step("post_req", 1'b1, 3'd1);
    idle("post_req", 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
